timestamp_serial_arbiter: RTL

- Shares one byte-serial timestamp lane among NUM_CHN requesters, such as sensor channels or compressor channels.
- Each requester pulses a request. The block then snapshots the live sec/usec time for that channel.
- Pending snapshots are granted round-robin. Each granted snapshot goes out as a pre_stb pulse followed by a 7-byte message.
- Output format is the one consumed by the byte-to-parallel timestamp decoder: sec LSB first, then usec LSB first, 20-bit usec.

---
 rtl/timestamp_serial_arbiter_pkg.sv | 25 ++
 rtl/timestamp_rr_grant.sv | 34 +++
 rtl/timestamp_serial_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/timestamp_serial_arbiter_pkg.sv
// timestamp_serial_arbiter_pkg: shared message constants, FSM states and snapshot type. Rev 1.0
`default_nettype none

package timestamp_serial_arbiter_pkg;

  localparam int         MSG_LEN   = 7;
  localparam int         SEC_W     = 32;
  localparam int         USEC_W    = 20;
  localparam int         MSG_W     = 8 * MSG_LEN;
  localparam logic [2:0] BYTE_LAST = 3'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_BYTE = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEC_W-1:0]  sec;
    logic [USEC_W-1:0] usec;
  } snap_t;

endpackage

`default_nettype wire

// File: rtl/timestamp_rr_grant.sv
// timestamp_rr_grant: combinational round-robin pick of the first pending channel at or after ptr. Rev 1.0
`default_nettype none

module timestamp_rr_grant #(
  parameter int NUM_CHN  = 4,
  parameter int CHN_BITS = 2
) (
  input  logic [NUM_CHN-1:0]  pending,
  input  logic [CHN_BITS-1:0] ptr,
  output logic [NUM_CHN-1:0]  grant,
  output logic [CHN_BITS-1:0] idx,
  output logic                valid
);

  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int off = 0; off < NUM_CHN; off++) begin
      c = (int'(ptr) + off) % NUM_CHN;
      if (!valid && pending[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = CHN_BITS'(c);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timestamp_serial_arbiter.sv
// timestamp_serial_arbiter: snapshots live time per requester and serializes pending snapshots
// round-robin onto one byte lane (pre_stb, then sec LSB-first, then 20-bit usec LSB-first). Rev 1.0
`default_nettype none

module timestamp_serial_arbiter
  import timestamp_serial_arbiter_pkg::*;
#(
  parameter int NUM_CHN  = 4,
  parameter int CHN_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SEC_W-1:0]    live_sec,
  input  logic [USEC_W-1:0]   live_usec,
  input  logic [NUM_CHN-1:0]  req,
  output logic                pre_stb,
  output logic [7:0]          tdata,
  output logic [CHN_BITS-1:0] tchn,
  output logic                busy,
  output logic [NUM_CHN-1:0]  sent,
  output logic [NUM_CHN-1:0]  overrun
);

  state_t              state, state_nx;
  snap_t               slot [NUM_CHN];
  logic [NUM_CHN-1:0]  pending;
  logic [NUM_CHN-1:0]  ovr_q;
  logic [CHN_BITS-1:0] ptr;
  logic [CHN_BITS-1:0] chn;
  logic [MSG_W-1:0]    shreg;
  logic [2:0]          k;

  logic [NUM_CHN-1:0]  gnt_oh;
  logic [CHN_BITS-1:0] gnt_idx;
  logic                gnt_any;
  logic                last_byte;
  logic                do_grant;
  logic [CHN_BITS-1:0] next_ptr;

  timestamp_rr_grant #(
    .NUM_CHN  (NUM_CHN),
    .CHN_BITS (CHN_BITS)
  ) u_grant (
    .pending (pending),
    .ptr     (ptr),
    .grant   (gnt_oh),
    .idx     (gnt_idx),
    .valid   (gnt_any)
  );

  assign last_byte = (state == ST_BYTE) && (k == BYTE_LAST);
  assign do_grant  = gnt_any && ((state == ST_IDLE) || last_byte);
  assign next_ptr  = (gnt_idx == CHN_BITS'(NUM_CHN - 1)) ? '0 : gnt_idx + 1'b1;
  assign tchn      = chn;
  assign overrun   = ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pre_stb  = 1'b0;
    busy     = 1'b0;
    tdata    = '0;
    sent     = '0;
    case (state)
      ST_IDLE: begin
        if (gnt_any) state_nx = ST_PRE;
      end
      ST_PRE: begin
        pre_stb  = 1'b1;
        busy     = 1'b1;
        state_nx = ST_BYTE;
      end
      ST_BYTE: begin
        busy  = 1'b1;
        tdata = shreg[7:0];
        if (k == BYTE_LAST) begin
          sent[chn] = 1'b1;
          state_nx  = gnt_any ? ST_PRE : ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A request against a still-pending slot (including its grant cycle) is dropped, keeping the old time.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ovr_q   <= '0;
      ptr     <= '0;
      chn     <= '0;
      shreg   <= '0;
      k       <= '0;
    end else begin
      ovr_q   <= req & pending;
      pending <= (pending & ~(do_grant ? gnt_oh : '0)) | (req & ~pending);
      if (do_grant) begin
        chn   <= gnt_idx;
        ptr   <= next_ptr;
        shreg <= {4'b0, slot[gnt_idx].usec, slot[gnt_idx].sec};
      end else if (state == ST_BYTE) begin
        shreg <= shreg >> 8;
      end
      k <= ((state == ST_BYTE) && (k != BYTE_LAST)) ? k + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHN; i++) begin
      if (req[i] && !pending[i]) begin
        slot[i] <= '{sec: live_sec, usec: live_usec};
      end
    end
  end

endmodule

`default_nettype wire
